// File: rtl/freq_tracker.sv
// Frequency tracker: debounces per-frame dominant-bin results into a stable
// frequency with lock/lost status, challenger tracking and an idle timeout.
module freq_tracker #(
    parameter int STABLE_CNT = 3,
    parameter int TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic [3:0] freq,
    output logic       stable_valid,
    output logic [3:0] stable_freq,
    output logic       locked,
    output logic       lost,
    output logic [7:0] change_cnt
);

    localparam logic [3:0]  STABLE_N = 4'(STABLE_CNT);
    localparam logic [15:0] TMO      = 16'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

    state_t      state_q;
    logic        done_q;
    logic [3:0]  cand_q;
    logic [3:0]  run_q;
    logic [15:0] timer_q;
    logic        sv_q;
    logic [3:0]  sf_q;
    logic        locked_q;
    logic        lost_q;
    logic [7:0]  cnt_q;

    logic        accept;
    logic [3:0]  run_inc;
    logic        cand_hit;
    logic        run_done;
    logic [15:0] timer_inc;
    logic [7:0]  cnt_inc;

    assign accept    = done & ~done_q;
    assign run_inc   = run_q + 4'd1;
    assign cand_hit  = (freq == cand_q);
    assign run_done  = cand_hit && (run_inc == STABLE_N);
    assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;
    assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            cand_q   <= 4'd0;
            run_q    <= 4'd0;
            timer_q  <= 16'd0;
            sv_q     <= 1'b0;
            sf_q     <= 4'd0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            done_q <= done;
            sv_q   <= 1'b0;
            if (accept)
                lost_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= 16'd0;
                    if (accept) begin
                        cand_q  <= freq;
                        run_q   <= 4'd1;
                        state_q <= ACQ;
                    end
                end
                ACQ: begin
                    // An accept in the expiry cycle wins over the timeout.
                    if (accept) begin
                        timer_q <= 16'd0;
                        if (run_done) begin
                            state_q  <= LOCK;
                            sf_q     <= cand_q;
                            locked_q <= 1'b1;
                            sv_q     <= 1'b1;
                            cnt_q    <= cnt_inc;
                            run_q    <= 4'd0;
                        end else if (cand_hit) begin
                            run_q <= run_inc;
                        end else begin
                            cand_q <= freq;
                            run_q  <= 4'd1;
                        end
                    end else if (timer_q == TMO) begin
                        state_q <= IDLE;
                        run_q   <= 4'd0;
                        timer_q <= 16'd0;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                LOCK: begin
                    if (accept) begin
                        timer_q <= 16'd0;
                        if (freq == sf_q) begin
                            run_q <= 4'd0;
                        end else if (run_done) begin
                            sf_q  <= cand_q;
                            sv_q  <= 1'b1;
                            cnt_q <= cnt_inc;
                            run_q <= 4'd0;
                        end else if (cand_hit) begin
                            // run may be 0 after a reset-by-incumbent; +1 restarts it.
                            run_q <= run_inc;
                        end else begin
                            cand_q <= freq;
                            run_q  <= 4'd1;
                        end
                    end else if (timer_q == TMO) begin
                        state_q  <= IDLE;
                        locked_q <= 1'b0;
                        lost_q   <= 1'b1;
                        run_q    <= 4'd0;
                        timer_q  <= 16'd0;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stable_valid = sv_q;
    assign stable_freq  = sf_q;
    assign locked       = locked_q;
    assign lost         = lost_q;
    assign change_cnt   = cnt_q;

endmodule
